cacheline_bmem_adapter: RTL and testbench

//  Sits between mp4's I-cache/D-cache miss ports and burst_memory (bmem_itf) for CP2+.

---
 rtl/cacheline_bmem_adapter.sv | 165 ++++++++++++++++
 tb/tb_cacheline_bmem_adapter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_bmem_adapter.sv
// I/D line-miss arbiter that serialises 256-bit lines into 64-bit bmem bursts.
// Define BMEM_ARB_RR_EN for round-robin grants; otherwise D-cache has fixed priority.
module cacheline_bmem_adapter #(
    parameter int ADDR_W      = 32,
    parameter int BEAT_W      = 64,
    parameter int BURST_BEATS = 4,
    localparam int LINE_W     = BEAT_W * BURST_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_BEATS,
        WR_BURST,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              gnt_d_q, gnt_d_d;
    logic              d_req;
    logic              i_req;
    logic              pick_d;
    logic [BEAT_W-1:0] wbeat;

    assign d_req = d_read | d_write;
    assign i_req = i_read;

`ifdef BMEM_ARB_RR_EN
    // Only contested grants move the pointer; a lone request never changes fairness.
    logic last_d_q, last_d_d;
    logic contested;

    always_comb begin
        contested = d_req & i_req;
        pick_d    = contested ? ~last_d_q : d_req;
        last_d_d  = last_d_q;
        if (state_q == IDLE && contested) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        addr_d     = addr_q;
        gnt_d_d    = gnt_d_q;
        unique case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    gnt_d_d    = pick_d;
                    beat_cnt_d = '0;
                    if (pick_d) begin
                        addr_d = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        addr_d = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                    if (pick_d && d_write) begin
                        line_d  = d_wdata;
                        state_d = WR_BURST;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_BEATS;
            RD_BEATS: begin
                if (bmem_resp) begin
                    for (int b = 0; b < BURST_BEATS; b++) begin
                        if (beat_cnt_q == CNT_W'(b)) begin
                            line_d[b*BEAT_W +: BEAT_W] = bmem_rdata;
                        end
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbeat = '0;
        for (int b = 0; b < BURST_BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
                wbeat = line_q[b*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            gnt_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            gnt_d_q    <= gnt_d_d;
        end
    end

    // Outputs derive only from flops, so reset clears them asynchronously.
    always_comb begin
        bmem_read  = (state_q == RD_ISSUE);
        bmem_write = (state_q == WR_BURST) && (beat_cnt_q == '0);
        bmem_addr  = (state_q == IDLE) ? '0 : addr_q;
        bmem_wdata = (state_q == WR_BURST) ? wbeat : '0;
        i_resp     = (state_q == DONE) && !gnt_d_q;
        d_resp     = (state_q == DONE) && gnt_d_q;
        i_rdata    = i_resp ? line_q : '0;
        d_rdata    = d_resp ? line_q : '0;
    end

endmodule

// File: tb/tb_cacheline_bmem_adapter.sv
// Scoreboard bench for cacheline_bmem_adapter: reads, writebacks, arbitration,
// gapped beats, reset abort and stray bmem responses.
module tb_cacheline_bmem_adapter;

    localparam int AW = 32;
    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_read = 1'b0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic [BW-1:0] bmem_rdata = '0;
    logic          bmem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            is_d;
        logic [LW-1:0] line;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [LW-1:0] mon_obs;

    bit            resp_en = 1'b0;
    int            gap = 0;
    bit            use_ovr = 1'b0;
    logic [BW-1:0] ovr[NB];
    logic [AW-1:0] rsp_a;

    cacheline_bmem_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_rdata (bmem_rdata),
        .bmem_resp  (bmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] beat_of(input logic [AW-1:0] a, input int k);
        if (use_ovr) return ovr[k];
        return {a, 32'(k + 1) * 32'h0101_0101};
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < NB; k++) l[k*BW +: BW] = beat_of(a, k);
        return l;
    endfunction

    // Memory model: answers each read issue with NB beats, gap idle cycles apart.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && bmem_read) begin
                rsp_a = bmem_addr;
                for (int k = 0; k < NB; k++) begin
                    @(negedge clk);
                    bmem_resp  = 1'b1;
                    bmem_rdata = beat_of(rsp_a, k);
                    for (int g = 0; g < gap; g++) begin
                        @(negedge clk);
                        bmem_resp = 1'b0;
                    end
                end
                if (gap == 0) begin
                    @(negedge clk);
                    bmem_resp = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every resp pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && (i_resp || d_resp)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b, none expected",
                         i_resp, d_resp);
            end else begin
                mon_e = exp_q.pop_front();
                if ((i_resp && d_resp) || (d_resp !== mon_e.is_d)) begin
                    errors++;
                    $display("FAIL resp_client: i_resp=%0b d_resp=%0b, expected is_d=%0b",
                             i_resp, d_resp, mon_e.is_d);
                end
                checks++;
                mon_obs = mon_e.is_d ? d_rdata : i_rdata;
                if (mon_obs !== mon_e.line) begin
                    errors++;
                    $display("FAIL resp_line: got %h expected %h", mon_obs, mon_e.line);
                end
            end
        end
    end

    task automatic wait_resp(input bit is_d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (is_d ? d_resp : i_resp) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL resp_timeout: is_d=%0b got no resp, expected one within %0d",
                     is_d, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({i_resp, d_resp, bmem_read, bmem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {i_resp, d_resp, bmem_read, bmem_write});
        end
        checks++;
        if (bmem_addr !== '0 || bmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bmem: addr=%h wdata=%h expected 0", bmem_addr, bmem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got nonzero line, expected 0");
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        bit seen;
        use_ovr = 1'b1;
        ovr = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        gap = 0;
        resp_en = 1'b1;
        exp_q.push_back(exp_t'{1'b0, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}});
        i_addr = 32'h6000_0024;
        i_read = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bmem_read) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL i_issue: bmem_read=0, expected 1");
        end
        checks++;
        if (bmem_addr !== 32'h6000_0020) begin
            errors++;
            $display("FAIL i_addr_mask: got %h expected 60000020", bmem_addr);
        end
        @(negedge clk);
        checks++;
        if (bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL i_issue_len: bmem_read=%b expected 0", bmem_read);
        end
        wait_resp(1'b0, 20);
        i_read = 1'b0;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0) begin
            errors++;
            $display("FAIL i_resp_pulse: i_resp=%b expected 0", i_resp);
        end
        @(negedge clk);
        use_ovr = 1'b0;
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wd;
        wd = {64'hD3D3_0000_3333_D3D3, 64'hD2D2_0000_2222_D2D2,
              64'hD1D1_0000_1111_D1D1, 64'hD0D0_0000_0000_D0D0};
        exp_q.push_back(exp_t'{1'b1, wd});
        d_addr  = 32'h8000_1047;
        d_wdata = wd;
        d_write = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (bmem_write !== (c == 1) || bmem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL d_wr_issue c%0d: write=%b read=%b expected %b 0",
                             c, bmem_write, bmem_read, (c == 1));
                end
                checks++;
                if (bmem_wdata !== wd[(c-1)*BW +: BW]) begin
                    errors++;
                    $display("FAIL d_wr_beat c%0d: got %h expected %h",
                             c, bmem_wdata, wd[(c-1)*BW +: BW]);
                end
                if (c == 1) begin
                    checks++;
                    if (bmem_addr !== 32'h8000_1040) begin
                        errors++;
                        $display("FAIL d_wr_addr: got %h expected 80001040", bmem_addr);
                    end
                end
            end else begin
                checks++;
                if (d_resp !== 1'b1) begin
                    errors++;
                    $display("FAIL d_wr_latency: d_resp=%b expected 1", d_resp);
                end
            end
        end
        d_write = 1'b0;
        d_wdata = '0;
        @(negedge clk);
        checks++;
        if (d_resp !== 1'b0 || bmem_write !== 1'b0) begin
            errors++;
            $display("FAIL d_wr_tail: d_resp=%b write=%b expected 0 0", d_resp, bmem_write);
        end
    endtask

    task automatic run_pair(input bit first_d, input logic [AW-1:0] ia, input logic [AW-1:0] da);
        bit di;
        bit dd;
        logic [LW-1:0] il;
        logic [LW-1:0] dl;
        il = line_of(ia & ~32'h0000_001F);
        dl = line_of(da & ~32'h0000_001F);
        exp_q.push_back(exp_t'{first_d, first_d ? dl : il});
        exp_q.push_back(exp_t'{!first_d, first_d ? il : dl});
        i_addr = ia;
        d_addr = da;
        i_read = 1'b1;
        d_read = 1'b1;
        di = 1'b0;
        dd = 1'b0;
        for (int n = 0; n < 60 && !(di && dd); n++) begin
            @(negedge clk);
            if (i_resp) begin
                i_read = 1'b0;
                di = 1'b1;
            end
            if (d_resp) begin
                d_read = 1'b0;
                dd = 1'b1;
            end
        end
        checks++;
        if (!(di && dd)) begin
            errors++;
            $display("FAIL pair_timeout: i_done=%b d_done=%b expected 1 1", di, dd);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        gap = 0;
        resp_en = 1'b1;
        run_pair(1'b1, 32'h0000_1100, 32'h1234_567F);
`ifdef BMEM_ARB_RR_EN
        run_pair(1'b0, 32'h0000_2200, 32'h0ABC_0040);
`else
        run_pair(1'b1, 32'h0000_2200, 32'h0ABC_0040);
`endif
    endtask

    task automatic test_gapped();
        gap = 2;
        resp_en = 1'b1;
        exp_q.push_back(exp_t'{1'b0, line_of(32'h0000_0A40)});
        i_addr = 32'h0000_0A5C;
        i_read = 1'b1;
        wait_resp(1'b0, 40);
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL gap_single: i_resp=%b read=%b expected 0 0", i_resp, bmem_read);
        end
        gap = 0;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        resp_en = 1'b0;
        i_addr = 32'h7000_0000;
        i_read = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bmem_read) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || bmem_addr !== 32'h7000_0000) begin
            errors++;
            $display("FAIL rst_pre: read=%b addr=%h expected 1 70000000", seen, bmem_addr);
        end
        @(negedge clk);
        bmem_resp  = 1'b1;
        bmem_rdata = 64'hAAAA_0000_0000_0001;
        @(negedge clk);
        bmem_rdata = 64'hAAAA_0000_0000_0002;
        @(negedge clk);
        bmem_resp = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bmem_addr !== '0 || {i_resp, d_resp, bmem_read, bmem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: addr=%h ctrl=%b expected 0",
                     bmem_addr, {i_resp, d_resp, bmem_read, bmem_write});
        end
        i_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bmem_resp  = 1'b1;
            bmem_rdata = 64'hBAD0_0000_0000_0000 | 64'(k);
        end
        @(negedge clk);
        bmem_resp = 1'b0;
        checks++;
        if (i_resp !== 1'b0 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_stray: i_resp=%b read=%b expected 0 0", i_resp, bmem_read);
        end
        resp_en = 1'b1;
        exp_q.push_back(exp_t'{1'b0, line_of(32'h7000_0100)});
        i_addr = 32'h7000_0100;
        i_read = 1'b1;
        wait_resp(1'b0, 20);
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_resp();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bmem_resp  = 1'b1;
            bmem_rdata = 64'hFEED_0000_0000_0000 | 64'(k);
        end
        @(negedge clk);
        bmem_resp = 1'b0;
        checks++;
        if ({i_resp, d_resp, bmem_read, bmem_write} !== 4'b0000 || bmem_addr !== '0) begin
            errors++;
            $display("FAIL stray_idle: ctrl=%b addr=%h expected 0",
                     {i_resp, d_resp, bmem_read, bmem_write}, bmem_addr);
        end
        gap = 1;
        resp_en = 1'b1;
        exp_q.push_back(exp_t'{1'b1, line_of(32'h0000_3FE0)});
        d_addr = 32'h0000_3FE8;
        d_read = 1'b1;
        wait_resp(1'b1, 30);
        d_read = 1'b0;
        repeat (2) @(negedge clk);
        gap = 0;
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, expected completion");
                $fatal(1);
            end
        join_none
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_gapped();
        test_reset_mid_read();
        test_stray_resp();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
